// File: rtl/sid_voice_feeder.sv
// Voice-sample producer for the SID filter: snapshots three voices plus external audio per
// sample tick, scales each waveform by its envelope on one shared multiplier, and strobes the result.
module sid_voice_feeder #(
  parameter int MIN_GAP = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_sample,
  input  logic [11:0] wave1,
  input  logic [11:0] wave2,
  input  logic [11:0] wave3,
  input  logic [7:0]  env1,
  input  logic [7:0]  env2,
  input  logic [7:0]  env3,
  input  logic [15:0] ext_pcm,
  input  logic        ovr_clr,
  output logic [11:0] voice1,
  output logic [11:0] voice2,
  output logic [11:0] voice3,
  output logic [11:0] ext_in,
  output logic        input_valid,
  output logic        busy,
  output logic        overrun
);
  localparam logic [2:0] IDLE = 3'd0, MUL1 = 3'd1, MUL2 = 3'd2, MUL3 = 3'd3,
                         EMIT = 3'd4, GAP = 3'd5;
  // A frame occupies IDLE+MUL1..3+EMIT = 5 cycles; GAP pads the rest so back-to-back
  // frames strobe exactly MIN_GAP cycles apart.
  localparam bit         HAS_GAP  = (MIN_GAP > 5);
  localparam logic [7:0] GAP_LOAD = 8'(HAS_GAP ? MIN_GAP - 6 : 0);

  logic [2:0]        state;
  logic [7:0]        gap_cnt;
  logic              pending;
  logic [2:0][11:0]  wave_s;
  logic [2:0][7:0]   env_s;
  logic [11:0]       ext_s;
  logic [2:0][11:0]  r;

  logic [11:0]        mul_w;
  logic [7:0]         mul_e;
  logic signed [11:0] s;
  logic signed [20:0] p;
  logic               unused_bits;
  logic               ovr_evt;

  always_comb begin
    mul_w = wave_s[0];
    mul_e = env_s[0];
    case (state)
      MUL2: begin mul_w = wave_s[1]; mul_e = env_s[1]; end
      MUL3: begin mul_w = wave_s[2]; mul_e = env_s[2]; end
      default: ;
    endcase
  end

  // Offset-binary to two's complement, then scale; p[19:8] floors toward -inf.
  assign s = $signed(mul_w ^ 12'h800);
  assign p = $signed({{9{s[11]}}, s}) * $signed({13'b0, mul_e});
  assign unused_bits = ^{p[20], p[7:0]};

  assign busy    = (state != IDLE);
  assign ovr_evt = ce_sample && busy && pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      pending     <= 1'b0;
      wave_s      <= '0;
      env_s       <= '0;
      ext_s       <= '0;
      r           <= '0;
      voice1      <= '0;
      voice2      <= '0;
      voice3      <= '0;
      ext_in      <= '0;
      input_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      input_valid <= 1'b0;
      overrun     <= ovr_evt | (overrun & ~ovr_clr);
      if (ce_sample && busy && !pending) pending <= 1'b1;
      case (state)
        IDLE: if (ce_sample || pending) begin
          wave_s  <= {wave3, wave2, wave1};
          env_s   <= {env3, env2, env1};
          ext_s   <= ext_pcm[15:4];
          pending <= 1'b0;
          state   <= MUL1;
        end
        MUL1: begin r[0] <= p[19:8]; state <= MUL2; end
        MUL2: begin r[1] <= p[19:8]; state <= MUL3; end
        MUL3: begin r[2] <= p[19:8]; state <= EMIT; end
        EMIT: begin
          voice1      <= r[0];
          voice2      <= r[1];
          voice3      <= r[2];
          ext_in      <= ext_s;
          input_valid <= 1'b1;
          gap_cnt     <= GAP_LOAD;
          state       <= HAS_GAP ? GAP : IDLE;
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
